// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle control FSM and its control-word decoder.
package multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        REXEC  = 4'd7,
        RWB    = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b110001;
    localparam logic [5:0] OP_ANDI = 6'b110000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(16'h0000);

endpackage

// File: rtl/control_word_decode.sv
// Moore map from FSM state to datapath control word; FETCH strobes PC/IR on the MemReady handshake.
module control_word_decode
    import multicycle_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // State to control-word table; IDLE, TRAP and unknown states drive every strobe low
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_RTYPE;
            end
            RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ITYPE;
            end
            IWB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: state register, next-state logic, retired-fetch counter and trap flag.
// Define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes in a sticky TRAP state instead of treating them as NOPs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       OpCode,
    input  logic             MemReady,
    input  logic             Zero,
    output logic [1:0]       ALUOp,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic [CNT_W-1:0] InstrCount,
    output logic             IllegalOp
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] instr_count_r;
    ctrl_t            ctrl_s;
    // Zero is consumed outside this block (gated with PCWriteCond)
    logic             unused_zero_s;

    assign unused_zero_s = Zero;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_op_r;
    assign IllegalOp = illegal_op_r;
`else
    assign IllegalOp = 1'b0;
`endif

    // State sequencing, retired-fetch count and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            instr_count_r <= {CNT_W{1'b0}};
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE:   state_r <= FETCH;
                FETCH: begin
                    if (MemReady) begin
                        state_r       <= DECODE;
                        instr_count_r <= instr_count_r + CNT_ONE;
                    end
                end
                DECODE: begin
                    case (OpCode)
                        OP_LW, OP_SW:     state_r <= MEMADR;
                        OP_R:             state_r <= REXEC;
                        OP_ADDI, OP_ANDI: state_r <= IEXEC;
                        OP_BEQ:           state_r <= BRANCH;
                        OP_J:             state_r <= JUMP;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            state_r      <= TRAP;
                            illegal_op_r <= 1'b1;
`else
                            state_r      <= FETCH;
`endif
                        end
                    endcase
                end
                MEMADR: state_r <= (OpCode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  state_r <= MemReady ? MEMWB : MEMRD;
                MEMWR:  state_r <= MemReady ? FETCH : MEMWR;
                MEMWB, RWB, IWB, BRANCH, JUMP: state_r <= FETCH;
                REXEC:  state_r <= RWB;
                IEXEC:  state_r <= IWB;
`ifdef ILLEGAL_OP_TRAP_EN
                TRAP:   state_r <= TRAP;
`endif
                default: state_r <= IDLE;
            endcase
        end
    end

    control_word_decode u_decode (
        .state     (state_r),
        .mem_ready (MemReady),
        .ctrl      (ctrl_s)
    );

    assign ALUOp       = ctrl_s.alu_op;
    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign PCSource    = ctrl_s.pc_source;
    assign IorD        = ctrl_s.iord;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign IRWrite     = ctrl_s.ir_write;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign RegDst      = ctrl_s.reg_dst;
    assign MemToReg    = ctrl_s.mem_to_reg;
    assign RegWrite    = ctrl_s.reg_write;
    assign InstrCount  = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4); expected control words are hand-computed per state.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [5:0]       OpCode;
    logic             MemReady;
    logic             Zero;
    logic [1:0]       ALUOp;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSource;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegDst;
    logic             MemToReg;
    logic             RegWrite;
    logic [CNT_W-1:0] InstrCount;
    logic             IllegalOp;

    int n_assert = 0;
    int n_fail   = 0;

    // Field order: ALUOp PCWrite PCWriteCond PCSource IorD MemRead MemWrite IRWrite ALUSrcA ALUSrcB RegDst MemToReg RegWrite
    logic [15:0] cw;
    assign cw = {ALUOp, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
                 IRWrite, ALUSrcA, ALUSrcB, RegDst, MemToReg, RegWrite};

    localparam logic [15:0] CW_NONE   = 16'b00_0_0_00_0_0_0_0_0_00_0_0_0;
    localparam logic [15:0] CW_FETCH  = 16'b00_1_0_00_0_1_0_1_0_01_0_0_0;
    localparam logic [15:0] CW_DECODE = 16'b00_0_0_00_0_0_0_0_0_11_0_0_0;
    localparam logic [15:0] CW_REXEC  = 16'b10_0_0_00_0_0_0_0_1_00_0_0_0;
    localparam logic [15:0] CW_RWB    = 16'b00_0_0_00_0_0_0_0_0_00_1_0_1;
    localparam logic [15:0] CW_MEMADR = 16'b00_0_0_00_0_0_0_0_1_10_0_0_0;
    localparam logic [15:0] CW_MEMRD  = 16'b00_0_0_00_1_1_0_0_0_00_0_0_0;
    localparam logic [15:0] CW_MEMWB  = 16'b00_0_0_00_0_0_0_0_0_00_0_1_1;
    localparam logic [15:0] CW_IEXEC  = 16'b11_0_0_00_0_0_0_0_1_10_0_0_0;
    localparam logic [15:0] CW_IWB    = 16'b00_0_0_00_0_0_0_0_0_00_0_0_1;
    localparam logic [15:0] CW_BRANCH = 16'b01_0_1_01_0_0_0_0_1_00_0_0_0;
    localparam logic [15:0] CW_JUMP   = 16'b00_1_0_10_0_0_0_0_0_00_0_0_0;
    localparam logic [15:0] CW_MEMWR  = 16'b00_0_0_00_1_0_1_0_0_00_0_0_0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .OpCode(OpCode), .MemReady(MemReady), .Zero(Zero),
        .ALUOp(ALUOp), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .InstrCount(InstrCount), .IllegalOp(IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        MemReady = 1'b1;
        OpCode   = 6'b000000;
        Zero     = 1'b0;

        // 1: reset and IDLE
        tick();
        tick();
        chk("idle_cw", 32'(cw), 32'(CW_NONE));
        chk("idle_cnt", 32'(InstrCount), 32'd0);
        chk("idle_illegal", 32'(IllegalOp), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("fetch_cw", 32'(cw), 32'(CW_FETCH));
        chk("fetch_cnt", 32'(InstrCount), 32'd0);

        // 2: R-type
        tick();
        chk("r_decode", 32'(cw), 32'(CW_DECODE));
        chk("r_cnt", 32'(InstrCount), 32'd1);
        tick();
        chk("r_rexec", 32'(cw), 32'(CW_REXEC));
        tick();
        chk("r_rwb", 32'(cw), 32'(CW_RWB));
        tick();
        chk("r_fetch", 32'(cw), 32'(CW_FETCH));

        // 3: LW with three wait states in MEMRD
        OpCode = 6'b100011;
        tick();
        chk("lw_decode", 32'(cw), 32'(CW_DECODE));
        tick();
        chk("lw_memadr", 32'(cw), 32'(CW_MEMADR));
        MemReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lw_memrd%0d", i), 32'(cw), 32'(CW_MEMRD));
            if (i == 3) MemReady = 1'b1;
            else        MemReady = 1'b0;
            tick();
        end
        chk("lw_memwb", 32'(cw), 32'(CW_MEMWB));
        tick();
        chk("lw_fetch", 32'(cw), 32'(CW_FETCH));
        chk("lw_cnt", 32'(InstrCount), 32'd2);

        // 4: ADDI then BEQ
        OpCode = 6'b110001;
        tick();
        tick();
        chk("addi_iexec", 32'(cw), 32'(CW_IEXEC));
        tick();
        chk("addi_iwb", 32'(cw), 32'(CW_IWB));
        tick();
        OpCode = 6'b000100;
        tick();
        chk("beq_cnt", 32'(InstrCount), 32'd4);
        tick();
        chk("beq_branch", 32'(cw), 32'(CW_BRANCH));
        tick();
        chk("beq_fetch", 32'(cw), 32'(CW_FETCH));

        // 5: unlisted opcode
        OpCode = 6'b111111;
        tick();
        chk("ill_decode", 32'(cw), 32'(CW_DECODE));
        tick();
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_trap_cw", 32'(cw), 32'(CW_NONE));
        chk("ill_flag", 32'(IllegalOp), 32'd1);
        tick();
        tick();
        chk("ill_trap_hold", 32'(cw), 32'(CW_NONE));
        chk("ill_flag_hold", 32'(IllegalOp), 32'd1);
        chk("ill_cnt_frozen", 32'(InstrCount), 32'd5);
`else
        chk("ill_nop_fetch", 32'(cw), 32'(CW_FETCH));
        chk("ill_flag", 32'(IllegalOp), 32'd0);
        chk("ill_cnt", 32'(InstrCount), 32'd5);
`endif
        reset_n = 1'b0;
        tick();
        chk("rst2_cw", 32'(cw), 32'(CW_NONE));
        chk("rst2_cnt", 32'(InstrCount), 32'd0);
        chk("rst2_flag", 32'(IllegalOp), 32'd0);
        reset_n = 1'b1;
        tick();

        // 6: 16 jumps wrap the 4-bit counter
        OpCode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) chk("j_cnt15", 32'(InstrCount), 32'd15);
            tick();
            if (i == 0) chk("j_jump", 32'(cw), 32'(CW_JUMP));
            tick();
        end
        chk("j_wrap", 32'(InstrCount), 32'd0);
        chk("j_fetch", 32'(cw), 32'(CW_FETCH));

        // SW stalled in MEMWR, aborted by reset
        OpCode = 6'b101011;
        tick();
        tick();
        chk("sw_memadr", 32'(cw), 32'(CW_MEMADR));
        MemReady = 1'b0;
        tick();
        chk("sw_memwr", 32'(cw), 32'(CW_MEMWR));
        tick();
        chk("sw_memwr_wait", 32'(cw), 32'(CW_MEMWR));
        reset_n = 1'b0;
        tick();
        chk("sw_rst_cw", 32'(cw), 32'(CW_NONE));
        chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("sw_rst_cnt", 32'(InstrCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
